// File: rtl/dcache_fill.sv
// Line fill / writeback sequencer below the data cache: drains a dirty victim,
// writes it to memory, then fetches the new line and streams it into the cache.
module dcache_fill #(
  parameter int LINE_LENGTH = 4,
  parameter int PA          = 22
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                push,
  input  logic                                pull,
  input  logic                                fault,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   fill_addr,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   wb_addr,
  input  logic [3:0]                          dwrite,
  output logic                                rstrobe_d,
  output logic                                wstrobe_d,
  output logic [3:0]                          dread,
  output logic                                busy,
  output logic                                done,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [PA-$clog2(LINE_LENGTH)-1:0]   mem_addr,
  input  logic                                mem_gnt,
  output logic                                mem_wvalid,
  output logic [3:0]                          mem_wdata,
  input  logic                                mem_wready,
  input  logic                                mem_rvalid,
  input  logic [3:0]                          mem_rdata
);
  localparam int NNIB = 2 * LINE_LENGTH;
  localparam int CW   = $clog2(NNIB);
  localparam int AW   = PA - $clog2(LINE_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

  typedef enum logic [2:0] {
    IDLE, WB_DRAIN, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, FILL_PUSH, DONE
  } state_t;

  typedef struct packed {
    logic          push;
    logic          pull;
    logic [AW-1:0] fill;
    logic [AW-1:0] wb;
  } req_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, nxt_cnt;
  req_t          req, src;
  logic          accept;
  logic [3:0]    nib_buf [NNIB];

  assign accept = (state == IDLE) && start && !fault && (push || pull);

  // In IDLE the command fields come straight from the inputs so the first
  // command cycle can carry the address being latched on the same edge.
  always_comb begin
    src = req;
    if (state == IDLE) begin
      src.push = push;
      src.pull = pull;
      src.fill = fill_addr;
      src.wb   = wb_addr;
    end
  end

  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    unique case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (accept) nxt = push ? WB_DRAIN : FILL_CMD;
      end
      WB_DRAIN: begin
        nxt_cnt = cnt + CW'(1);
        if (cnt == LAST) nxt = WB_CMD;
      end
      WB_CMD: begin
        nxt_cnt = '0;
        if (mem_gnt) nxt = WB_DATA;
      end
      WB_DATA: begin
        if (mem_wready) begin
          nxt_cnt = cnt + CW'(1);
          if (cnt == LAST) nxt = req.pull ? FILL_CMD : DONE;
        end
      end
      FILL_CMD: begin
        nxt_cnt = '0;
        if (mem_gnt) nxt = FILL_DATA;
      end
      FILL_DATA: begin
        if (mem_rvalid) begin
          nxt_cnt = cnt + CW'(1);
          if (cnt == LAST) nxt = FILL_PUSH;
        end
      end
      FILL_PUSH: begin
        nxt_cnt = cnt + CW'(1);
        if (cnt == LAST) nxt = DONE;
      end
      DONE: begin
        nxt_cnt = '0;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so every output is a pure
  // flop and the cache side never sees a combinational path from mem_*.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req        <= '0;
      rstrobe_d  <= 1'b0;
      wstrobe_d  <= 1'b0;
      dread      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wvalid <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      state      <= nxt;
      cnt        <= nxt_cnt;
      if (accept) req <= src;
      busy       <= (nxt != IDLE);
      done       <= (nxt == DONE);
      rstrobe_d  <= (nxt == WB_DRAIN);
      wstrobe_d  <= (nxt == FILL_PUSH);
      mem_req    <= (nxt == WB_CMD) || (nxt == FILL_CMD);
      mem_we     <= (nxt == WB_CMD);
      mem_addr   <= (nxt == WB_CMD) ? src.wb : (nxt == FILL_CMD) ? src.fill : '0;
      mem_wvalid <= (nxt == WB_DATA);
      mem_wdata  <= (nxt == WB_DATA) ? nib_buf[nxt_cnt] : '0;
      dread      <= (nxt == FILL_PUSH) ? nib_buf[nxt_cnt] : '0;
    end
  end

  // Buffer contents are don't-care across reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (state == WB_DRAIN)
      nib_buf[cnt] <= dwrite;
    else if (state == FILL_DATA && mem_rvalid)
      nib_buf[cnt] <= mem_rdata;
  end
endmodule

// File: tb/tb_dcache_fill.sv
// Self-checking bench for dcache_fill: a cycle-level memory/cache responder
// with randomized stalls, checked against transaction-level expectations.
module tb_dcache_fill;
  localparam int LL   = 4;
  localparam int PA   = 22;
  localparam int NNIB = 2 * LL;
  localparam int AW   = PA - $clog2(LL);

  logic          clk = 0, reset = 1, start = 0, push = 0, pull = 0, fault = 0;
  logic [AW-1:0] fill_addr = '0, wb_addr = '0, mem_addr;
  logic [3:0]    dwrite = '0, dread, mem_wdata, mem_rdata = '0;
  logic          rstrobe_d, wstrobe_d, busy, done, mem_req, mem_we, mem_wvalid;
  logic          mem_gnt = 0, mem_wready = 0, mem_rvalid = 0;
  int            checks = 0, failures = 0;
  logic [3:0]    vic [NNIB];
  logic [3:0]    line [NNIB];

  always #5 clk = ~clk;

  dcache_fill #(.LINE_LENGTH(LL), .PA(PA)) dut (
    .clk(clk), .reset(reset), .start(start), .push(push), .pull(pull),
    .fault(fault), .fill_addr(fill_addr), .wb_addr(wb_addr), .dwrite(dwrite),
    .rstrobe_d(rstrobe_d), .wstrobe_d(wstrobe_d), .dread(dread), .busy(busy),
    .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({rstrobe_d, wstrobe_d, dread, busy, done, mem_req, mem_we,
                mem_addr, mem_wvalid, mem_wdata});
  endfunction

  // mode 0: zero-wait memory, 1: grant after 3 cycles and 1,0,1,0 handshakes,
  // 2: random handshakes. abort_nib >= 0 asserts reset on that fill nibble.
  task automatic run(input string tag, input bit p_push, input bit p_pull,
                     input logic [AW-1:0] fa, input logic [AW-1:0] wa,
                     input int mode, input int abort_nib);
    logic [3:0]  wq[$], rq[$];
    logic [AW:0] cq[$], eq[$];
    int nrd, c, dn, rs_first, rs_n, last_rs, ws_first, ws_n, last_ws;
    int stalls, req_run, last_wr;
    bit rd_on, rd_next, fin, aborting, g, w, r, tw, tr;
    nrd = 0; c = 0; dn = -1; rs_first = -1; rs_n = 0; last_rs = -1;
    ws_first = -1; ws_n = 0; last_ws = -1; stalls = 0; req_run = 0; last_wr = -1;
    rd_on = 0; rd_next = 0; fin = 0; aborting = 0; tw = 1; tr = 1;
    while (!fin && c < 400) begin
      @(negedge clk);
      rd_on = rd_on || rd_next;
      rd_next = 0;
      // second start at cycle 5 lands while busy and must be ignored
      start = (c == 0 || c == 5);
      if (c == 0) begin
        fault = 0; push = p_push; pull = p_pull; fill_addr = fa; wb_addr = wa;
      end else begin
        fault = 1'($urandom); push = 1'($urandom); pull = 1'($urandom);
        fill_addr = AW'($urandom); wb_addr = AW'($urandom);
      end
      chk({tag, " busy"}, 64'(busy), 64'(c > 0));
      chk({tag, " strobe overlap"}, 64'(rstrobe_d && wstrobe_d), 64'd0);
      chk({tag, " strobe with req"}, 64'((rstrobe_d || wstrobe_d) && mem_req), 64'd0);
      if (mem_req) begin
        g = (mode == 0) ? 1'b1 : (mode == 1) ? (req_run >= 3) : 1'($urandom);
        req_run++;
        mem_gnt = g;
        if (g) begin
          cq.push_back({mem_we, mem_addr});
          if (!mem_we) rd_next = 1;
          req_run = 0;
        end else stalls++;
      end else begin
        mem_gnt = 1'($urandom);
        req_run = 0;
      end
      if (rstrobe_d) begin
        dwrite = vic[rs_n % NNIB];
        if (rs_first < 0) rs_first = c;
        rs_n++; last_rs = c;
      end else dwrite = 4'($urandom);
      if (mem_wvalid) begin
        w = (mode == 0) ? 1'b1 : (mode == 1) ? tw : 1'($urandom);
        if (mode == 1) tw = !tw;
        mem_wready = w;
        if (w) begin wq.push_back(mem_wdata); last_wr = c; end
        else stalls++;
      end else mem_wready = 1'($urandom);
      if (rd_on && nrd < NNIB) begin
        r = (mode == 0) ? 1'b1 : (mode == 1) ? tr : 1'($urandom);
        if (mode == 1) tr = !tr;
        mem_rvalid = r;
        mem_rdata = r ? line[nrd] : 4'($urandom);
        if (r) begin
          if (nrd == abort_nib) begin reset = 1; aborting = 1; end
          nrd++;
        end else stalls++;
      end else begin
        mem_rvalid = 1'($urandom);
        mem_rdata = 4'($urandom);
      end
      if (wstrobe_d) begin
        rq.push_back(dread);
        if (ws_first < 0) ws_first = c;
        ws_n++; last_ws = c;
      end
      if (done) begin dn = c; fin = 1; end
      if (aborting) fin = 1;
      c++;
    end
    if (aborting) begin
      @(negedge clk);
      chk({tag, " outputs after reset"}, outs(), 64'd0);
      reset = 0; start = 0; mem_gnt = 0; mem_wready = 0; mem_rvalid = 0;
      @(negedge clk);
      chk({tag, " idle after reset"}, outs(), 64'd0);
    end else begin
      start = 0;
      chk({tag, " done reached"}, 64'(fin), 64'd1);
      if (p_push) eq.push_back({1'b1, wa});
      if (p_pull) eq.push_back({1'b0, fa});
      chk({tag, " cmd count"}, 64'(cq.size()), 64'(eq.size()));
      foreach (eq[i]) if (i < cq.size()) chk({tag, " cmd we/addr"}, 64'(cq[i]), 64'(eq[i]));
      chk({tag, " wr nibble count"}, 64'(wq.size()), 64'(p_push ? NNIB : 0));
      foreach (wq[i]) if (i < NNIB) chk({tag, " wr nibble"}, 64'(wq[i]), 64'(vic[i]));
      chk({tag, " fill nibble count"}, 64'(rq.size()), 64'(p_pull ? NNIB : 0));
      foreach (rq[i]) if (i < NNIB) chk({tag, " fill nibble"}, 64'(rq[i]), 64'(line[i]));
      chk({tag, " drain strobes"}, 64'(rs_n), 64'(p_push ? NNIB : 0));
      if (p_push) begin
        chk({tag, " drain start"}, 64'(rs_first), 64'd1);
        chk({tag, " drain contiguous"}, 64'(last_rs - rs_first + 1), 64'(NNIB));
      end
      if (p_pull) begin
        chk({tag, " fill strobes"}, 64'(ws_n), 64'(NNIB));
        chk({tag, " fill contiguous"}, 64'(last_ws - ws_first + 1), 64'(NNIB));
        chk({tag, " fill burst end"}, 64'(ws_first), 64'(dn - NNIB));
      end else begin
        chk({tag, " done after last wready"}, 64'(dn), 64'(last_wr + 1));
      end
      chk({tag, " done cycle"}, 64'(dn),
          64'(1 + (p_push ? 2*NNIB + 1 : 0) + (p_pull ? 2*NNIB + 1 : 0) + stalls));
      @(negedge clk);
      chk({tag, " idle after done"}, outs(), 64'd0);
    end
  endtask

  task automatic idle_probe(input string tag, input bit f, input bit p, input bit q);
    @(negedge clk);
    start = 1; fault = f; push = p; pull = q;
    fill_addr = AW'($urandom); wb_addr = AW'($urandom);
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, " quiet"}, outs(), 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [AW-1:0] a1, a2;
    bit pp, pl;
    repeat (2) @(negedge clk);
    chk("reset outputs", outs(), 64'd0);
    reset = 0;

    for (int i = 0; i < NNIB; i++) line[i] = 4'(i);
    run("fill_only", 0, 1, AW'('h12345), AW'($urandom), 0, -1);

    for (int i = 0; i < NNIB; i++) begin vic[i] = 4'(15 - i); line[i] = 4'($urandom); end
    run("wb_fill", 1, 1, AW'($urandom), AW'('h00AA0), 0, -1);

    for (int i = 0; i < NNIB; i++) begin vic[i] = 4'($urandom); line[i] = 4'($urandom); end
    run("stalls", 1, 1, AW'($urandom), AW'($urandom), 1, -1);

    for (int i = 0; i < NNIB; i++) vic[i] = 4'($urandom);
    run("push_only", 1, 0, AW'($urandom), AW'($urandom), 0, -1);
    run("push_only_stall", 1, 0, AW'($urandom), AW'($urandom), 1, -1);

    idle_probe("fault", 1, 1, 1);
    idle_probe("no_push_no_pull", 0, 0, 0);

    for (int i = 0; i < NNIB; i++) line[i] = 4'($urandom);
    run("abort", 0, 1, AW'($urandom), AW'($urandom), 0, 4);
    for (int i = 0; i < NNIB; i++) line[i] = 4'($urandom);
    run("after_abort", 0, 1, AW'($urandom), AW'($urandom), 0, -1);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NNIB; i++) begin vic[i] = 4'($urandom); line[i] = 4'($urandom); end
      pp = 1'($urandom); pl = 1'($urandom);
      if (!pp && !pl) pl = 1;
      a1 = AW'($urandom); a2 = AW'($urandom);
      run("random", pp, pl, a1, a2, 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
